// File: rtl/aurora_cmd_wbbridge.sv
// aurora_cmd_wbbridge: turns the Aurora command generator's split address /
// write-data streams into single classic Wishbone cycles and returns read data
// on a one-deep response stream.
// A read is only accepted while the response register is empty, so every read
// has a place to land and response backpressure never stalls a bus cycle.
// Optional: define CMDWB_TIMEOUT_EN to abort a bus cycle that has not
// terminated after TIMEOUT_CYCLES cycles; the abort is handled like err_i.
module aurora_cmd_wbbridge #(
    parameter int          ADDR_BITS      = 22,
    parameter logic [31:0] ERR_VALUE      = 32'hBAD0BAD0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [31:0]          s_cmd_addr_tdata,
    input  logic                 s_cmd_addr_tvalid,
    output logic                 s_cmd_addr_tready,
    input  logic [31:0]          s_cmd_data_tdata,
    input  logic                 s_cmd_data_tvalid,
    output logic                 s_cmd_data_tready,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_BITS-1:0] wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic [31:0]          m_resp_tdata,
    output logic                 m_resp_tvalid,
    input  logic                 m_resp_tready,
    output logic                 bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [31:0]            resp_data_q, resp_data_d;
    logic                   bus_err_q, bus_err_d;

    logic                   cmd_is_read;
    logic                   rd_accept;
    logic                   wr_accept;
    logic                   tmo_hit;
    logic                   term;
    logic                   term_err;

    // Address bits above ADDR_BITS (below the read flag) carry no meaning here.
    logic                   unused_ok;
    assign unused_ok = ^{s_cmd_addr_tdata[30:ADDR_BITS], (TIMEOUT_CYCLES > 0)};

    // Accept decisions; the streams are popped only while IDLE and out of reset.
    assign cmd_is_read = s_cmd_addr_tdata[31];
    assign rd_accept   = !areset && (state_q == ST_IDLE) && s_cmd_addr_tvalid
                         && cmd_is_read && !resp_valid_q;
    assign wr_accept   = !areset && (state_q == ST_IDLE) && s_cmd_addr_tvalid
                         && !cmd_is_read && s_cmd_data_tvalid;

    assign s_cmd_addr_tready = rd_accept || wr_accept;
    assign s_cmd_data_tready = wr_accept;

`ifdef CMDWB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = cyc_q && !wb_ack_i && !wb_err_i
                     && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Cycle-age counter: restarts on every accept, counts unterminated bus cycles.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (rd_accept || wr_accept) begin
            tmo_cnt_d = '0;
        end else if (cyc_q && !wb_ack_i && !wb_err_i) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // A timeout ends the cycle exactly like an error; ack+err counts as error.
    assign term     = cyc_q && (wb_ack_i || wb_err_i || tmo_hit);
    assign term_err = wb_err_i || tmo_hit;

    // Next-state and next-output computation for the bridge FSM.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        bus_err_d    = 1'b0;

        if (resp_valid_q && m_resp_tready) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_accept) begin
                    adr_d   = s_cmd_addr_tdata[ADDR_BITS-1:0];
                    we_d    = 1'b0;
                    cyc_d   = 1'b1;
                    state_d = ST_READ;
                end else if (wr_accept) begin
                    adr_d   = s_cmd_addr_tdata[ADDR_BITS-1:0];
                    dat_d   = s_cmd_data_tdata;
                    we_d    = 1'b1;
                    cyc_d   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (term) begin
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    state_d   = ST_IDLE;
                    bus_err_d = term_err;
                    // The response register is known empty here: reads are
                    // only accepted when it is.
                    if (state_q == ST_READ) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = term_err ? ERR_VALUE : wb_dat_i;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Bridge FSM state and all registered outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = 4'hF;
    assign m_resp_tvalid = resp_valid_q;
    assign m_resp_tdata  = resp_data_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_aurora_cmd_wbbridge.sv
// Testbench for aurora_cmd_wbbridge: stream drivers, a randomized Wishbone
// slave and a response sink feed a scoreboard; a negedge monitor compares the
// DUT against expectations derived from the command list and slave behaviour.
// Build with CMDWB_TIMEOUT_EN defined to also exercise the bus timeout.
module tb_aurora_cmd_wbbridge;

    localparam int          ADDR_BITS = 22;
    localparam logic [31:0] ERR_VALUE = 32'hBAD0BAD0;
    localparam int          TMO       = 16;
`ifdef CMDWB_TIMEOUT_EN
    localparam bit          TMO_EN    = 1'b1;
`else
    localparam bit          TMO_EN    = 1'b0;
`endif

    logic                 aclk;
    logic                 areset;
    logic [31:0]          s_cmd_addr_tdata;
    logic                 s_cmd_addr_tvalid;
    logic                 s_cmd_addr_tready;
    logic [31:0]          s_cmd_data_tdata;
    logic                 s_cmd_data_tvalid;
    logic                 s_cmd_data_tready;
    logic                 wb_cyc_o, wb_stb_o, wb_we_o;
    logic [ADDR_BITS-1:0] wb_adr_o;
    logic [31:0]          wb_dat_o;
    logic [3:0]           wb_sel_o;
    logic [31:0]          wb_dat_i;
    logic                 wb_ack_i, wb_err_i;
    logic [31:0]          m_resp_tdata;
    logic                 m_resp_tvalid;
    logic                 m_resp_tready;
    logic                 bus_err;

    aurora_cmd_wbbridge #(
        .ADDR_BITS     (ADDR_BITS),
        .ERR_VALUE     (ERR_VALUE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .s_cmd_addr_tdata (s_cmd_addr_tdata),
        .s_cmd_addr_tvalid(s_cmd_addr_tvalid),
        .s_cmd_addr_tready(s_cmd_addr_tready),
        .s_cmd_data_tdata (s_cmd_data_tdata),
        .s_cmd_data_tvalid(s_cmd_data_tvalid),
        .s_cmd_data_tready(s_cmd_data_tready),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_we_o          (wb_we_o),
        .wb_adr_o         (wb_adr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_sel_o         (wb_sel_o),
        .wb_dat_i         (wb_dat_i),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i),
        .m_resp_tdata     (m_resp_tdata),
        .m_resp_tvalid    (m_resp_tvalid),
        .m_resp_tready    (m_resp_tready),
        .bus_err          (bus_err)
    );

    typedef struct {
        logic                 we;
        logic [ADDR_BITS-1:0] adr;
        logic [31:0]          dat;
    } bus_t;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_resp_q[$];
    logic [31:0] cmd_q[$];
    logic [31:0] data_q[$];

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    int          cmd_gap_max  = 0;
    int          data_gap_min = 0;
    int          data_gap_max = 0;
    int          slave_min    = 1;
    int          slave_max    = 1;
    int          err_pct      = 0;
    bit          slave_hang   = 0;
    bit          force_err    = 0;
    bit          force_dat_en = 0;
    logic [31:0] force_dat    = '0;
    bit          stray_en     = 0;
    bit          rdy_rand     = 0;
    bit          rdy_force    = 1;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    task automatic issue(input bit rd, input logic [31:0] a, input logic [31:0] d);
        bus_t        e;
        logic [31:0] full;
        full     = a;
        full[31] = rd;
        e.we     = !rd;
        e.adr    = full[ADDR_BITS-1:0];
        e.dat    = d;
        exp_bus_q.push_back(e);
        cmd_q.push_back(full);
        if (!rd) data_q.push_back(d);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((cmd_q.size() != 0 || data_q.size() != 0 || exp_bus_q.size() != 0 ||
                exp_resp_q.size() != 0 || wb_cyc_o || m_resp_tvalid ||
                s_cmd_addr_tvalid || s_cmd_data_tvalid) && n < limit) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain_%s: traffic still pending after %0d cycles", name, limit);
        end
        repeat (2) @(negedge aclk);
    endtask

    // address stream driver
    initial begin
        logic [31:0] a;
        int          n;
        s_cmd_addr_tvalid = 1'b0;
        s_cmd_addr_tdata  = '0;
        forever begin
            @(posedge aclk); #1;
            if (cmd_q.size() != 0 && !areset) begin
                a = cmd_q.pop_front();
                n = $urandom_range(cmd_gap_max);
                for (int i = 0; i < n; i++) begin @(posedge aclk); #1; end
                s_cmd_addr_tdata  = a;
                s_cmd_addr_tvalid = 1'b1;
                do @(negedge aclk); while (!s_cmd_addr_tready);
                @(posedge aclk); #1;
                s_cmd_addr_tvalid = 1'b0;
                s_cmd_addr_tdata  = $urandom;
            end
        end
    end

    // write-data stream driver
    initial begin
        logic [31:0] d;
        int          n;
        s_cmd_data_tvalid = 1'b0;
        s_cmd_data_tdata  = '0;
        forever begin
            @(posedge aclk); #1;
            if (data_q.size() != 0 && !areset) begin
                d = data_q.pop_front();
                n = $urandom_range(data_gap_max, data_gap_min);
                for (int i = 0; i < n; i++) begin @(posedge aclk); #1; end
                s_cmd_data_tdata  = d;
                s_cmd_data_tvalid = 1'b1;
                do @(negedge aclk); while (!s_cmd_data_tready);
                @(posedge aclk); #1;
                s_cmd_data_tvalid = 1'b0;
                s_cmd_data_tdata  = $urandom;
            end
        end
    end

    // response sink
    initial begin
        m_resp_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            m_resp_tready = rdy_rand ? ($urandom_range(2) != 0) : rdy_force;
        end
    end

    // Wishbone slave: random wait states, optional errors, stray acks while idle
    initial begin
        int wait_cnt;
        int r;
        wait_cnt = 1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge aclk); #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o && wb_stb_o && !areset) begin
                if (!slave_hang) begin
                    if (wait_cnt == 0) begin
                        r = $urandom_range(99);
                        if (force_err) begin
                            wb_err_i = 1'b1;
                        end else if (r < err_pct) begin
                            wb_err_i = 1'b1;
                            wb_ack_i = ($urandom_range(1) == 1);
                        end else begin
                            wb_ack_i = 1'b1;
                        end
                        wb_dat_i = force_dat_en ? force_dat : $urandom;
                        wait_cnt = $urandom_range(slave_max, slave_min);
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                wb_dat_i = $urandom;
                if (stray_en) begin
                    wb_ack_i = ($urandom_range(3) == 0);
                    wb_err_i = ($urandom_range(7) == 0);
                end
            end
        end
    end

    // monitor / scoreboard
    bit          in_cyc        = 0;
    bit          exp_drop      = 0;
    bit          exp_cyc_next  = 0;
    bit          exp_berr      = 0;
    bit          exp_resp_next = 0;
    bit          resp_hold     = 0;
    bit          cur_we        = 0;
    logic [31:0] hold_data     = '0;
    int          cyc_cnt       = 0;

    always @(negedge aclk) begin
        bus_t        e;
        logic [31:0] er;
        bit          term, is_err, exp_ar, exp_dr;
        term   = 0;
        is_err = 0;
        if (areset) begin
            exp_resp_q.delete();
            in_cyc        = 0;
            exp_drop      = 0;
            exp_cyc_next  = 0;
            exp_berr      = 0;
            exp_resp_next = 0;
            resp_hold     = 0;
            cyc_cnt       = 0;
        end else begin
            if (exp_drop) begin
                chk("cyc_drop_after_term", {31'd0, wb_cyc_o}, 32'd0);
                in_cyc   = 0;
                exp_drop = 0;
            end
            if (exp_resp_next) begin
                chk("resp_valid_after_term", {31'd0, m_resp_tvalid}, 32'd1);
                exp_resp_next = 0;
            end
            if (wb_stb_o !== wb_cyc_o) chk("stb_follows_cyc", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});

            // bus cycle start
            if (!in_cyc && (wb_cyc_o || exp_cyc_next)) begin
                chk("cyc_after_accept", {31'd0, wb_cyc_o}, {31'd0, exp_cyc_next});
                if (wb_cyc_o) begin
                    if (exp_bus_q.size() == 0) begin
                        fail_now("bus_start", "bus cycle with no command outstanding");
                    end else begin
                        e = exp_bus_q.pop_front();
                        chk("bus_we", {31'd0, wb_we_o}, {31'd0, e.we});
                        chk("bus_adr", {10'd0, wb_adr_o}, {10'd0, e.adr});
                        if (e.we) chk("bus_dat", wb_dat_o, e.dat);
                    end
                    chk("bus_sel", {28'd0, wb_sel_o}, 32'hF);
                    if (!wb_we_o) chk("read_with_resp_pending", {31'd0, m_resp_tvalid}, 32'd0);
                    cur_we  = wb_we_o;
                    in_cyc  = 1;
                    cyc_cnt = 0;
                end
            end
            exp_cyc_next = s_cmd_addr_tvalid && s_cmd_addr_tready;

            // stream accept rules
            exp_ar = !wb_cyc_o && s_cmd_addr_tvalid &&
                     (s_cmd_addr_tdata[31] ? !m_resp_tvalid : s_cmd_data_tvalid);
            exp_dr = exp_ar && !s_cmd_addr_tdata[31];
            if (exp_ar || s_cmd_addr_tready)
                chk("addr_tready", {31'd0, s_cmd_addr_tready}, {31'd0, exp_ar});
            if (exp_dr || s_cmd_data_tready)
                chk("data_tready", {31'd0, s_cmd_data_tready}, {31'd0, exp_dr});

            // bus cycle termination (ack, err, or timeout)
            if (in_cyc && wb_cyc_o) begin
                cyc_cnt++;
                term   = wb_ack_i || wb_err_i || (TMO_EN && cyc_cnt == TMO);
                is_err = wb_err_i || !wb_ack_i;
                if (term) begin
                    if (!cur_we) begin
                        er = is_err ? ERR_VALUE : wb_dat_i;
                        exp_resp_q.push_back(er);
                        exp_resp_next = 1;
                    end
                    exp_drop = 1;
                    $display("bus %s adr=%h dat=%h err=%0d cycles=%0d",
                             cur_we ? "write" : "read ", wb_adr_o,
                             cur_we ? wb_dat_o : wb_dat_i, is_err, cyc_cnt);
                end
            end

            if (exp_berr || bus_err) chk("bus_err_pulse", {31'd0, bus_err}, {31'd0, exp_berr});
            exp_berr = term && is_err;

            // response stream
            if (resp_hold) begin
                chk("resp_valid_held", {31'd0, m_resp_tvalid}, 32'd1);
                chk("resp_data_stable", m_resp_tdata, hold_data);
            end
            if (m_resp_tvalid && m_resp_tready) begin
                if (exp_resp_q.size() == 0) begin
                    fail_now("resp_pop", "response accepted with none expected");
                end else begin
                    er = exp_resp_q.pop_front();
                    chk("resp_data", m_resp_tdata, er);
                    $display("resp data=%h", m_resp_tdata);
                end
            end else if (m_resp_tvalid && exp_resp_q.size() == 0) begin
                fail_now("resp_unexpected", "response valid with none expected");
            end
            resp_hold = m_resp_tvalid && !m_resp_tready;
            hold_data = m_resp_tdata;
        end
    end

    // main sequence
    initial begin
        logic [31:0] a;
        int          n;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'd0, wb_we_o}, 32'd0);
        chk("rst_adr", {10'd0, wb_adr_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_resp_valid", {31'd0, m_resp_tvalid}, 32'd0);
        chk("rst_resp_data", m_resp_tdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_addr_tready", {31'd0, s_cmd_addr_tready}, 32'd0);
        chk("rst_data_tready", {31'd0, s_cmd_data_tready}, 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;

        // single write, slave acks one cycle after stb
        issue(0, 32'h0000_0010, 32'h1234_5678);
        drain("write", 200);

        // single read returning a fixed word
        force_dat_en = 1;
        force_dat    = 32'hCAFE_F00D;
        issue(1, 32'h0000_0020, 32'h0);
        drain("read", 200);
        force_dat_en = 0;

        // response backpressure with two back-to-back reads
        rdy_force = 0;
        issue(1, 32'h0000_0100, 32'h0);
        issue(1, 32'h0000_0104, 32'h0);
        repeat (20) @(negedge aclk);
        chk("bp_resp_pending", {31'd0, m_resp_tvalid}, 32'd1);
        chk("bp_no_second_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("bp_addr_stalled", {31'd0, s_cmd_addr_tready}, 32'd0);
        rdy_force = 1;
        drain("backpressure", 200);

        // write data arrives five cycles after its address
        data_gap_min = 5;
        data_gap_max = 5;
        issue(0, 32'h0000_0200, 32'hA5A5_0001);
        drain("late_data", 200);
        data_gap_min = 0;
        data_gap_max = 0;

        // read terminated by err_i, stray acks while idle
        stray_en  = 1;
        force_err = 1;
        issue(1, 32'h0000_0300, 32'h0);
        drain("err_read", 200);
        force_err = 0;

        // randomized mix
        rdy_rand     = 1;
        err_pct      = 15;
        slave_min    = 0;
        slave_max    = 3;
        cmd_gap_max  = 3;
        data_gap_max = 6;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            issue($urandom_range(1) == 1, a, $urandom);
        end
        drain("random", 20000);

        // hung slave: only terminates via the timeout when it is built in
        if (TMO_EN) begin
            stray_en   = 0;
            slave_hang = 1;
            issue(1, 32'h0000_0400, 32'h0);
            drain("timeout", 200);
            slave_hang = 0;
        end

        // reset during an active read
        rdy_rand   = 0;
        rdy_force  = 1;
        stray_en   = 0;
        slave_hang = 1;
        issue(1, 32'h0000_0500, 32'h0);
        n = 0;
        while (!wb_cyc_o && n < 100) begin @(negedge aclk); n++; end
        chk("rst_mid_cyc_seen", {31'd0, wb_cyc_o}, 32'd1);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_mid_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_mid_no_resp", {31'd0, m_resp_tvalid}, 32'd0);
        slave_hang = 0;
        repeat (5) @(negedge aclk);
        chk("rst_mid_still_no_resp", {31'd0, m_resp_tvalid}, 32'd0);

        // recovery after reset
        slave_min = 1;
        slave_max = 1;
        issue(1, 32'h0000_0600, 32'h0);
        issue(0, 32'h0000_0604, 32'h0BAD_F00D);
        drain("after_reset", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
